// File: rtl/rr_out_arbiter.sv
// Round-robin arbiter for one shared output bit: one-hot grant, a registered data channel and an IDLE/BUSY/GAP FSM.
// Define ARB_TIMEOUT_EN to revoke a grant after HOLD_MAX cycles and pulse timeout.
module rr_out_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] din,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            out,
  output logic            timeout
);
  localparam int PTR_W = $clog2(NREQ);

  if (CNT_W < $clog2(HOLD_MAX) || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_cfg
    $error("rr_out_arbiter: HOLD_MAX must be 2..255 and CNT_W >= clog2(HOLD_MAX)");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, win_idx;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             out_q, out_d;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Scan downward so the last hit kept is the nearest requester after ptr.
  always_comb begin
    win_idx = ptr_q;
    for (int i = NREQ; i >= 1; i--) begin
      if (req[PTR_W'((int'(ptr_q) + i) % NREQ)]) begin
        win_idx = PTR_W'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    out_d   = out_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        out_d = 1'b0;
        if (|req) begin
          state_d = BUSY;
          ptr_d   = win_idx;
          gnt_d   = NREQ'(1) << win_idx;
          out_d   = din[win_idx];
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      BUSY: begin
`ifdef ARB_TIMEOUT_EN
        if (hold_cnt_q != CNT_W'(HOLD_MAX - 1)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
        if (!req[ptr_q]) begin
          state_d = GAP;
          gnt_d   = '0;
          out_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_cnt_q == CNT_W'(HOLD_MAX - 1)) begin
          // Holder still requesting at the limit: revoke and flag it.
          state_d   = GAP;
          gnt_d     = '0;
          out_d     = 1'b0;
          timeout_d = 1'b1;
`endif
        end else begin
          out_d = din[ptr_q];
        end
      end
      GAP: begin
        state_d = IDLE;
        gnt_d   = '0;
        out_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(NREQ - 1);
      gnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      out_q   <= out_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt  = gnt_q;
  assign out  = out_q;
  assign busy = |gnt_q;

endmodule

// File: tb/tb_rr_out_arbiter.sv
// Directed bench for rr_out_arbiter: vector table for arbitration/data path plus reset and hold-limit sequences.
module tb_rr_out_arbiter;
  logic       clk;
  logic       nrst;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic       busy;
  logic       out;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  rr_out_arbiter #(.NREQ(4), .HOLD_MAX(4), .CNT_W(8)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .req     (req),
    .din     (din),
    .gnt     (gnt),
    .busy    (busy),
    .out     (out),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic       out;
    logic       busy;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    req  = 4'b0000;
    din  = 4'b0000;
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    // ptr starts at 3 after reset; each row is one clock edge.
    tbl[0]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1};
    tbl[1]  = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1};
    tbl[2]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1};
    tbl[6]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b1};
    tbl[7]  = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0};
    tbl[9]  = '{4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[10] = '{4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1};
    tbl[11] = '{4'b1001, 4'b0000, 4'b1000, 1'b0, 1'b1};
    tbl[12] = '{4'b0001, 4'b1000, 4'b0000, 1'b0, 1'b0};
    tbl[13] = '{4'b1001, 4'b1001, 4'b0000, 1'b0, 1'b0};
    tbl[14] = '{4'b1001, 4'b1001, 4'b0001, 1'b1, 1'b1};
    tbl[15] = '{4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[16] = '{4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[17] = '{4'b1001, 4'b1000, 4'b1000, 1'b1, 1'b1};
    tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

    nrst = 1'b0;
    req  = 4'b1111;
    din  = 4'b1111;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    req  = 4'b0000;
    din  = 4'b0000;
    nrst = 1'b1;

    for (int v = 0; v < 20; v++) begin
      req = tbl[v].req;
      din = tbl[v].din;
      step();
      chk($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(tbl[v].gnt));
      chk($sformatf("vec%0d_out", v), 32'(out), 32'(tbl[v].out));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(tbl[v].busy));
      chk($sformatf("vec%0d_timeout", v), 32'(timeout), 32'h0);
    end

    // Asynchronous reset in the middle of a grant to requester 1.
    req = 4'b0010;
    din = 4'b0010;
    step();
    chk("pre_rst_gnt", 32'(gnt), 32'h2);
    chk("pre_rst_out", 32'(out), 32'h1);
    #2 nrst = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_out", 32'(out), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    chk("held_rst_gnt", 32'(gnt), 32'h0);
    chk("held_rst_timeout", 32'(timeout), 32'h0);
    nrst = 1'b1;
    step();
    chk("post_rst_gnt", 32'(gnt), 32'h2);
    chk("post_rst_timeout", 32'(timeout), 32'h0);
    req = 4'b0000;
    step();
    chk("post_rst_gap", 32'(gnt), 32'h0);
    step();

`ifdef ARB_TIMEOUT_EN
    pulse_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk($sformatf("hold%0d_c%0d_gnt", g, c), 32'(gnt), 32'(4'b0001 << (g % 4)));
        chk($sformatf("hold%0d_c%0d_timeout", g, c), 32'(timeout), 32'h0);
      end
      step();
      chk($sformatf("hold%0d_gap_gnt", g), 32'(gnt), 32'h0);
      chk($sformatf("hold%0d_gap_timeout", g), 32'(timeout), 32'h1);
      step();
      chk($sformatf("hold%0d_idle_gnt", g), 32'(gnt), 32'h0);
      chk($sformatf("hold%0d_idle_timeout", g), 32'(timeout), 32'h0);
    end
    req = 4'b0000;
    repeat (3) step();
`else
    pulse_reset();
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("long%0d_gnt", c), 32'(gnt), 32'h1);
      chk($sformatf("long%0d_timeout", c), 32'(timeout), 32'h0);
    end
    req = 4'b0000;
    step();
    chk("long_release_gnt", 32'(gnt), 32'h0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
